// File: rtl/kvs_c2h_packetizer.sv
// kvs_c2h_packetizer: frames one KVS response (header descriptor + value stream)
// into a C2H AXI-Stream packet: a 256-bit header beat, value beats, exact last tkeep.
module kvs_c2h_packetizer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter logic [31:0] MAGIC      = 32'h4C45474F
) (
  input  logic                    TX_clk,
  input  logic                    TX_rst_n,
  input  logic                    hdr_valid,
  output logic                    hdr_ready,
  input  logic [7:0]              hdr_opcode,
  input  logic [7:0]              hdr_status,
  input  logic [15:0]             hdr_len,
  input  logic [31:0]             hdr_seq,
  input  logic                    val_tvalid,
  output logic                    val_tready,
  input  logic [DATA_WIDTH-1:0]   val_tdata,
  input  logic                    val_tlast,
  output logic                    TX_tvalid,
  input  logic                    TX_tready,
  output logic [DATA_WIDTH-1:0]   TX_tdata,
  output logic [DATA_WIDTH/8-1:0] TX_tkeep,
  output logic                    TX_tlast,
  output logic [31:0]             pkt_count,
  output logic                    len_err
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned BEAT_W = 12;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned RSV_W  = DATA_WIDTH - 96;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN} state_t;

  typedef struct packed {
    logic [RSV_W-1:0] rsvd;
    logic [31:0]      magic;
    logic [31:0]      seq;
    logic [LEN_W-1:0] len;
    logic [7:0]       status;
    logic [7:0]       opcode;
  } c2h_hdr_t;

  state_t                state, state_d;
  logic [BEAT_W-1:0]     beats_left, beats_left_d;
  logic [4:0]            len_lo, len_lo_d;
  logic                  tvalid_d, tlast_d, len_err_d;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic [KEEP_W-1:0]     tkeep_d, keep_last;
  logic                  out_free;
  c2h_hdr_t              hdr_beat;

  assign out_free = !TX_tvalid || TX_tready;

  // Header beat assembled straight from the descriptor inputs
  always_comb begin
    hdr_beat        = '0;
    hdr_beat.opcode = hdr_opcode;
    hdr_beat.status = hdr_status;
    hdr_beat.len    = hdr_len;
    hdr_beat.seq    = hdr_seq;
    hdr_beat.magic  = MAGIC;
  end

  // Byte enables for the final value beat; a residue of 0 means a full beat
  always_comb begin
    if (len_lo == 5'd0) keep_last = '1;
    else                keep_last = KEEP_W'((33'd1 << len_lo) - 33'd1);
  end

  // Next-state, output-register load and ready generation
  always_comb begin
    state_d      = state;
    beats_left_d = beats_left;
    len_lo_d     = len_lo;
    len_err_d    = len_err;
    tvalid_d     = TX_tvalid && !TX_tready;
    tdata_d      = TX_tdata;
    tkeep_d      = TX_tkeep;
    tlast_d      = TX_tlast;
    hdr_ready    = 1'b0;
    val_tready   = 1'b0;

    unique case (state)
      S_IDLE: begin
        hdr_ready = out_free;
        if (hdr_valid && out_free) begin
          tvalid_d     = 1'b1;
          tdata_d      = hdr_beat;
          tkeep_d      = '1;
          tlast_d      = (hdr_len == 16'd0);
          len_lo_d     = hdr_len[4:0];
          beats_left_d = BEAT_W'((17'(hdr_len) + 17'd31) >> 5);
          state_d      = (hdr_len == 16'd0) ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        val_tready = out_free;
        if (val_tvalid && out_free) begin
          tvalid_d     = 1'b1;
          tdata_d      = val_tdata;
          beats_left_d = beats_left - BEAT_W'(1);
          if (beats_left == BEAT_W'(1)) begin
            tlast_d = 1'b1;
            tkeep_d = keep_last;
            if (val_tlast) begin
              state_d = S_IDLE;
            end else begin
              len_err_d = 1'b1;
              state_d   = S_DRAIN;
            end
          end else if (val_tlast) begin
            // Short stream: close the packet on this beat
            tlast_d   = 1'b1;
            tkeep_d   = '1;
            len_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            tlast_d = 1'b0;
            tkeep_d = '1;
          end
        end
      end
      S_DRAIN: begin
        val_tready = 1'b1;
        if (val_tvalid && val_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Readies stay low while reset is held
    hdr_ready  = hdr_ready && TX_rst_n;
    val_tready = val_tready && TX_rst_n;
  end

  // State and output registers
  always_ff @(posedge TX_clk or negedge TX_rst_n) begin
    if (!TX_rst_n) begin
      state      <= S_IDLE;
      beats_left <= '0;
      len_lo     <= '0;
      len_err    <= 1'b0;
      TX_tvalid  <= 1'b0;
      TX_tdata   <= '0;
      TX_tkeep   <= '0;
      TX_tlast   <= 1'b0;
      pkt_count  <= '0;
    end else begin
      state      <= state_d;
      beats_left <= beats_left_d;
      len_lo     <= len_lo_d;
      len_err    <= len_err_d;
      TX_tvalid  <= tvalid_d;
      TX_tdata   <= tdata_d;
      TX_tkeep   <= tkeep_d;
      TX_tlast   <= tlast_d;
      if (TX_tvalid && TX_tready && TX_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_kvs_c2h_packetizer.sv
// Randomized bench for kvs_c2h_packetizer: a packet-level model predicts every
// C2H beat, a negedge monitor compares the DUT against it each cycle.
module tb_kvs_c2h_packetizer;

  localparam logic [31:0] MAGIC = 32'h4C45474F;

  logic         TX_clk = 1'b0;
  logic         TX_rst_n = 1'b0;
  logic         hdr_valid = 1'b0;
  logic         hdr_ready;
  logic [7:0]   hdr_opcode = '0;
  logic [7:0]   hdr_status = '0;
  logic [15:0]  hdr_len = '0;
  logic [31:0]  hdr_seq = '0;
  logic         val_tvalid = 1'b0;
  logic         val_tready;
  logic [255:0] val_tdata = '0;
  logic         val_tlast = 1'b0;
  logic         TX_tvalid;
  logic         TX_tready = 1'b1;
  logic [255:0] TX_tdata;
  logic [31:0]  TX_tkeep;
  logic         TX_tlast;
  logic [31:0]  pkt_count;
  logic         len_err;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tready_mode = 2;
  int          exp_pkts = 0;
  bit          exp_len_err = 1'b0;
  int          last_pkt_beats = 0;
  logic [31:0] last_pkt_keep = '0;
  logic [31:0] last_hdr_magic = '0;

  kvs_c2h_packetizer #(.DATA_WIDTH(256), .MAGIC(MAGIC)) dut (
    .TX_clk(TX_clk), .TX_rst_n(TX_rst_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_opcode(hdr_opcode), .hdr_status(hdr_status),
    .hdr_len(hdr_len), .hdr_seq(hdr_seq),
    .val_tvalid(val_tvalid), .val_tready(val_tready),
    .val_tdata(val_tdata), .val_tlast(val_tlast),
    .TX_tvalid(TX_tvalid), .TX_tready(TX_tready),
    .TX_tdata(TX_tdata), .TX_tkeep(TX_tkeep), .TX_tlast(TX_tlast),
    .pkt_count(pkt_count), .len_err(len_err)
  );

  always #5 TX_clk = ~TX_clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sink backpressure: 0 = random, 1 = toggle each cycle, 2 = always ready
  initial begin
    forever begin
      @(posedge TX_clk); #1;
      case (tready_mode)
        0:       TX_tready = ($urandom_range(0, 3) != 0);
        1:       TX_tready = !TX_tready;
        default: TX_tready = 1'b1;
      endcase
    end
  end

  // Per-cycle compare against the expected beat queue
  initial begin : mon
    int    pkt_beats;
    bit    stall;
    beat_t held;
    beat_t e;
    pkt_beats = 0;
    stall = 1'b0;
    forever begin
      @(negedge TX_clk);
      if (!TX_rst_n) begin
        stall = 1'b0;
        pkt_beats = 0;
        exp_pkts = 0;
        continue;
      end
      chk("pkt_count", 256'(pkt_count), 256'(exp_pkts));
      if (stall) begin
        chk("stall_valid", 256'(TX_tvalid), 256'(1));
        chk("stall_data", TX_tdata, held.data);
        chk("stall_keep", 256'(TX_tkeep), 256'(held.keep));
        chk("stall_last", 256'(TX_tlast), 256'(held.last));
      end
      stall = TX_tvalid && !TX_tready;
      held = '{TX_tdata, TX_tkeep, TX_tlast};
      if (TX_tvalid && TX_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got beat %0h expected none", TX_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", TX_tdata, e.data);
          chk("tkeep", 256'(TX_tkeep), 256'(e.keep));
          chk("tlast", 256'(TX_tlast), 256'(e.last));
          if (pkt_beats == 0) last_hdr_magic = TX_tdata[95:64];
          pkt_beats++;
          if (e.last) begin
            exp_pkts++;
            last_pkt_beats = pkt_beats;
            last_pkt_keep = TX_tkeep;
            pkt_beats = 0;
          end
        end
      end
    end
  end

  task automatic align();
    @(posedge TX_clk); #1;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [7:0] st,
                          input logic [15:0] len, input logic [31:0] seq);
    int n = 0;
    hdr_opcode = op;
    hdr_status = st;
    hdr_len = len;
    hdr_seq = seq;
    hdr_valid = 1'b1;
    do begin
      @(negedge TX_clk);
      n++;
    end while (!hdr_ready && n < 2000);
    if (!hdr_ready) begin
      checks++;
      errors++;
      $display("FAIL hdr_timeout: got no hdr_ready expected accept for len %0d", len);
    end
    @(posedge TX_clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic send_val(input logic [255:0] d, input logic last);
    int n = 0;
    val_tdata = d;
    val_tlast = last;
    val_tvalid = 1'b1;
    do begin
      @(negedge TX_clk);
      n++;
    end while (!val_tready && n < 2000);
    if (!val_tready) begin
      checks++;
      errors++;
      $display("FAIL val_timeout: got no val_tready expected accept");
    end
    @(posedge TX_clk); #1;
    val_tvalid = 1'b0;
    val_tlast = 1'b0;
  endtask

  // Model: header beat, then min(streamed, needed) value beats
  task automatic run_pkt(input logic [7:0] op, input logic [31:0] seq, input logic [15:0] len,
                         input int nbeats_in, input bit gaps, input int limit);
    int           nb, k, r, nbeats;
    logic [31:0]  lk;
    logic [7:0]   st;
    logic [255:0] d[$];
    beat_t        b;
    nbeats = (len == 16'd0) ? 0 : nbeats_in;
    nb = (int'(len) + 31) / 32;
    r = int'(len) % 32;
    lk = (r == 0) ? 32'hFFFFFFFF : (32'hFFFFFFFF >> (32 - r));
    st = 8'($urandom());
    b.data = {160'd0, MAGIC, seq, len, st, op};
    b.keep = 32'hFFFFFFFF;
    b.last = (len == 16'd0);
    exp_q.push_back(b);
    for (int i = 0; i < nbeats; i++)
      d.push_back({$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()});
    k = (nbeats < nb) ? nbeats : nb;
    for (int i = 1; i <= k; i++) begin
      b.data = d[i-1];
      b.keep = (i == nb) ? lk : 32'hFFFFFFFF;
      b.last = (i == k);
      exp_q.push_back(b);
    end
    if (len != 16'd0 && nbeats != nb) exp_len_err = 1'b1;
    send_hdr(op, st, len, seq);
    for (int i = 0; i < nbeats && i < limit; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) align();
      send_val(d[i], i == nbeats - 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge TX_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    @(negedge TX_clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 256'(TX_tvalid), 256'(0));
    chk({tag, "_tdata"}, TX_tdata, 256'(0));
    chk({tag, "_tkeep"}, 256'(TX_tkeep), 256'(0));
    chk({tag, "_tlast"}, 256'(TX_tlast), 256'(0));
    chk({tag, "_hdr_ready"}, 256'(hdr_ready), 256'(0));
    chk({tag, "_val_tready"}, 256'(val_tready), 256'(0));
    chk({tag, "_pkt_count"}, 256'(pkt_count), 256'(0));
    chk({tag, "_len_err"}, 256'(len_err), 256'(0));
  endtask

  initial begin
    int          sel, nb, nbeats;
    logic [15:0] len;
    repeat (3) @(posedge TX_clk);
    #1;
    chk_outputs_zero("reset");
    TX_rst_n = 1'b1;
    align();

    // Zero-length response
    run_pkt(8'h02, 32'h11, 16'd0, 0, 1'b0, 1000);
    wait_drain();
    chk("zl_beats", 256'(last_pkt_beats), 256'(1));
    chk("zl_keep", 256'(last_pkt_keep), 256'(32'hFFFFFFFF));
    chk("zl_magic", 256'(last_hdr_magic), 256'(32'h4C45474F));
    chk("zl_pkt_count", 256'(pkt_count), 256'(1));
    align();

    // Partial last beat
    run_pkt(8'h10, 32'h22, 16'd70, 3, 1'b1, 1000);
    wait_drain();
    chk("p70_beats", 256'(last_pkt_beats), 256'(4));
    chk("p70_keep", 256'(last_pkt_keep), 256'(32'h0000003F));
    chk("p70_len_err", 256'(len_err), 256'(0));
    align();

    // Exact multiple under toggling backpressure
    tready_mode = 1;
    run_pkt(8'h11, 32'h33, 16'd64, 2, 1'b0, 1000);
    wait_drain();
    chk("p64_beats", 256'(last_pkt_beats), 256'(3));
    chk("p64_keep", 256'(last_pkt_keep), 256'(32'hFFFFFFFF));
    chk("p64_pkt_count", 256'(pkt_count), 256'(3));
    tready_mode = 2;
    align();

    // Early val_tlast, then a normal packet
    run_pkt(8'h12, 32'h44, 16'd100, 2, 1'b1, 1000);
    wait_drain();
    chk("early_beats", 256'(last_pkt_beats), 256'(3));
    chk("early_len_err", 256'(len_err), 256'(1));
    align();
    run_pkt(8'h13, 32'h55, 16'd32, 1, 1'b0, 1000);
    wait_drain();
    chk("after_early_beats", 256'(last_pkt_beats), 256'(2));
    align();

    // Late val_tlast: extra beats drained
    run_pkt(8'h14, 32'h66, 16'd32, 3, 1'b1, 1000);
    wait_drain();
    chk("late_beats", 256'(last_pkt_beats), 256'(2));
    chk("late_pkt_count", 256'(pkt_count), 256'(6));
    align();

    // Maximum length
    run_pkt(8'h15, 32'h77, 16'd65535, 2048, 1'b0, 100000);
    wait_drain();
    chk("max_beats", 256'(last_pkt_beats), 256'(2049));
    chk("max_keep", 256'(last_pkt_keep), 256'(32'h7FFFFFFF));
    align();

    // Reset in the middle of a 10-beat packet
    tready_mode = 0;
    run_pkt(8'h16, 32'h88, 16'd320, 10, 1'b1, 3);
    #2;
    TX_rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_len_err = 1'b0;
    chk_outputs_zero("midrst");
    repeat (2) @(negedge TX_clk);
    align();
    TX_rst_n = 1'b1;
    align();
    run_pkt(8'h17, 32'h99, 16'd32, 1, 1'b0, 1000);
    wait_drain();
    chk("rst_beats", 256'(last_pkt_beats), 256'(2));
    chk("rst_pkt_count", 256'(pkt_count), 256'(1));
    align();

    // Randomized traffic, back-to-back where the driver allows
    for (int p = 0; p < 150; p++) begin
      tready_mode = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)     len = 16'd0;
      else if (sel < 3) len = 16'($urandom_range(1, 32));
      else if (sel < 9) len = 16'($urandom_range(33, 400));
      else              len = 16'($urandom_range(401, 1500));
      nb = (int'(len) + 31) / 32;
      nbeats = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb + 2)) : nb;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) align();
      run_pkt(8'($urandom()), $urandom(), len, nbeats, 1'($urandom_range(0, 1)), 100000);
      chk("rand_len_err", 256'(len_err), 256'(exp_len_err));
    end
    tready_mode = 2;
    wait_drain();
    chk("final_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
